// File: rtl/sqrt_pipe.sv
// -----------------------------------------------------------------------------
// sqrt_pipe -- fully pipelined unsigned integer square root.
//
// Computes floor(sqrt(X)) and the remainder X - root^2 for a W-bit operand,
// resolving one root bit per stage (R = W/2 stages, MSB bit pair first).
// A sideband tag travels with each operand. The whole pipeline advances as
// one unit under a single enable, so a stalled output freezes every stage.
//
// Parameters
//   W      operand width, even and >= 4 (root width R = W/2)
//   TAG_W  sideband tag width, >= 1
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operand present on i_x / i_in_tag
//   o_in_ready   operand accepted this cycle when also i_in_valid
//   i_x          unsigned radicand
//   i_in_tag     opaque tag returned with the result
//   o_out_valid  o_root / o_rem / o_out_tag valid
//   i_out_ready  downstream accepts the result this cycle
//   o_root       floor(sqrt(X)), R bits
//   o_rem        X - root^2, R+1 bits
//   o_out_tag    tag of this result
// -----------------------------------------------------------------------------
module sqrt_pipe #(
    parameter int W     = 16,
    parameter int TAG_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [W-1:0]       i_x,
    input  logic [TAG_W-1:0]   i_in_tag,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [W/2-1:0]     o_root,
    output logic [W/2:0]       o_rem,
    output logic [TAG_W-1:0]   o_out_tag
);

    localparam int R  = W / 2;     // number of stages / root width
    localparam int RW = R + 1;     // remainder width
    localparam int CW = R + 3;     // compare width for the trial subtraction

    // Stage registers. r_x only exists for stages 0..R-2: the last stage has
    // no operand bits left to pass on.
    logic [R-1:0]     r_v;
    logic [W-1:0]     r_x   [R-1];
    logic [R-1:0]     r_q   [R];
    logic [RW-1:0]    r_r   [R];
    logic [TAG_W-1:0] r_tag [R];

    // Per-stage combinational inputs and results.
    logic [R-1:0]     w_q_in  [R];
    logic [RW-1:0]    w_r_in  [R];
    logic [1:0]       w_pair  [R];
    logic [CW-1:0]    w_rp    [R];
    logic [CW-1:0]    w_t     [R];
    logic [R-1:0]     w_q_nxt [R];
    logic [RW-1:0]    w_r_nxt [R];
    logic [W-1:0]     w_x_nxt [R-1];
    logic             w_en;

    // A slot may advance whenever the output slot is empty or being consumed.
    assign w_en        = i_out_ready | ~r_v[R-1];
    assign o_in_ready  = w_en;
    assign o_out_valid = r_v[R-1];
    assign o_root      = r_q[R-1];
    assign o_rem       = r_r[R-1];
    assign o_out_tag   = r_tag[R-1];

    // NOTE: every element is assigned on every pass through this block
    // (stage 0 explicitly, the rest by the loops), so no latch is inferred.
    always_comb begin
        // Stage 0 starts from q = r = 0 and the top bit pair of the operand.
        w_q_in[0]  = '0;
        w_r_in[0]  = '0;
        w_pair[0]  = i_x[W-1:W-2];
        w_x_nxt[0] = {i_x[W-3:0], 2'b00};
        for (int s = 1; s < R; s++) begin
            w_q_in[s] = r_q[s-1];
            w_r_in[s] = r_r[s-1];
            w_pair[s] = r_x[s-1][W-1:W-2];
        end
        // Remaining operand bits are kept left-aligned so the next pair is
        // always the top two bits.
        for (int s = 1; s < R - 1; s++) begin
            w_x_nxt[s] = {r_x[s-1][W-3:0], 2'b00};
        end
        for (int s = 0; s < R; s++) begin
            w_rp[s] = {w_r_in[s], w_pair[s]};
            w_t[s]  = {1'b0, w_q_in[s], 2'b01};
            // Compare at full width, truncate only afterwards: the result
            // is bounded by 2q and always fits in RW bits.
            if (w_rp[s] >= w_t[s]) begin
                w_r_nxt[s] = RW'(w_rp[s] - w_t[s]);
                w_q_nxt[s] = {w_q_in[s][R-2:0], 1'b1};
            end else begin
                w_r_nxt[s] = w_rp[s][RW-1:0];
                w_q_nxt[s] = {w_q_in[s][R-2:0], 1'b0};
            end
        end
    end

    // NOTE: the data registers are reset along with the valid bits because
    // the outputs must read zero after reset, not just be flagged invalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v <= '0;
            for (int s = 0; s < R - 1; s++) r_x[s] <= '0;
            for (int s = 0; s < R; s++) begin
                r_q[s]   <= '0;
                r_r[s]   <= '0;
                r_tag[s] <= '0;
            end
        end else if (w_en) begin
            // NOTE: non-blocking assignments let every stage sample its
            // predecessor's old value, which is what makes this a shift.
            r_v      <= {r_v[R-2:0], i_in_valid};
            r_tag[0] <= i_in_tag;
            for (int s = 1; s < R; s++) r_tag[s] <= r_tag[s-1];
            for (int s = 0; s < R - 1; s++) r_x[s] <= w_x_nxt[s];
            for (int s = 0; s < R; s++) begin
                r_q[s] <= w_q_nxt[s];
                r_r[s] <= w_r_nxt[s];
            end
        end
    end

endmodule
